// File: rtl/vga_timing_generator.sv
// VGA timing generator: walks the pixel/line counters shared with the PPU,
// delays sync and blanking to match the PPU's colour latency, and drives
// 2-bit-per-channel RGB plus frame/vblank status for the game logic.
module vga_timing_generator #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FRONT        = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BACK         = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FRONT        = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BACK         = 33,
  parameter int COLOUR_LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       colour,
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [5:0] rgb,
  output logic       vblank,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int LAT     = COLOUR_LATENCY;

  // Last counter value of each phase; the phase changes on the following edge.
  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END  = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] H_SY_END  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END  = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] V_SY_END  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  phase_t h_state, h_next;
  phase_t v_state, v_next;
  logic   h_last, v_last, frame_wrap;

  assign h_last     = (counter_H == H_LAST);
  assign v_last     = (counter_V == V_LAST);
  assign frame_wrap = h_last && v_last;

  // Phase state registers for both axes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_state <= PH_ACTIVE;
      v_state <= PH_ACTIVE;
    end else begin
      h_state <= h_next;
      v_state <= v_next;
    end
  end

  // Horizontal phase steps every pixel, leaving a phase at its last column.
  always_comb begin
    h_next = h_state;
    case (h_state)
      PH_ACTIVE: if (counter_H == H_ACT_END) h_next = PH_FRONT;
      PH_FRONT:  if (counter_H == H_FP_END)  h_next = PH_SYNC;
      PH_SYNC:   if (counter_H == H_SY_END)  h_next = PH_BACK;
      PH_BACK:   if (h_last)                 h_next = PH_ACTIVE;
      default:                               h_next = PH_ACTIVE;
    endcase
  end

  // Vertical phase only moves on the horizontal wrap.
  always_comb begin
    v_next = v_state;
    if (h_last) begin
      case (v_state)
        PH_ACTIVE: if (counter_V == V_ACT_END) v_next = PH_FRONT;
        PH_FRONT:  if (counter_V == V_FP_END)  v_next = PH_SYNC;
        PH_SYNC:   if (counter_V == V_SY_END)  v_next = PH_BACK;
        PH_BACK:   if (v_last)                 v_next = PH_ACTIVE;
        default:                               v_next = PH_ACTIVE;
      endcase
    end
  end

  // Pixel/line counters presented to the PPU.
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter_H <= '0;
      counter_V <= '0;
    end else if (h_last) begin
      counter_H <= '0;
      counter_V <= v_last ? 10'd0 : counter_V + 10'd1;
    end else begin
      counter_H <= counter_H + 10'd1;
    end
  end

  // Frame pulse and count update together on the (last,last) -> (0,0) edge,
  // so a reset never looks like a frame start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap) frame_count <= frame_count + 8'd1;
    end
  end

  // vblank follows the counters directly so game logic sees it undelayed.
  assign vblank = (v_state != PH_ACTIVE);

  // Delay line: index 0 is the raw per-position value, index k is k cycles old.
  logic           act_raw, hs_raw, vs_raw;
  logic [LAT-1:0] act_q, hs_q, vs_q;
  logic [LAT:0]   act_pipe, hs_pipe, vs_pipe;

  assign act_raw  = (h_state == PH_ACTIVE) && (v_state == PH_ACTIVE);
  assign hs_raw   = (h_state != PH_SYNC);
  assign vs_raw   = (v_state != PH_SYNC);
  assign act_pipe = {act_q, act_raw};
  assign hs_pipe  = {hs_q, hs_raw};
  assign vs_pipe  = {vs_q, vs_raw};

  // Shift the blanking/sync history; reset flushes it so no stale pulse leaks out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      act_q <= '0;
      hs_q  <= '1;
      vs_q  <= '1;
    end else begin
      act_q <= act_pipe[LAT-1:0];
      hs_q  <= hs_pipe[LAT-1:0];
      vs_q  <= vs_pipe[LAT-1:0];
    end
  end

  assign display_on = act_pipe[LAT];
  assign hsync      = hs_pipe[LAT];
  assign vsync      = vs_pipe[LAT];

  // Colour arrives one cycle before output; register it, forced black outside active video.
  always_ff @(posedge clk) begin
    if (!reset) rgb <= '0;
    else        rgb <= act_pipe[LAT-1] ? {6{colour}} : 6'b0;
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator using a shrunken timing so whole frames
// (and 256 of them) fit in a short run. The reference model derives every
// output from the cycle count since reset release with plain arithmetic.
module tb_vga_timing_generator;

  localparam int HA = 6, HF = 1, HS = 3, HB = 2;
  localparam int VA = 5, VF = 1, VS = 2, VB = 2;
  localparam int LAT = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       colour = 1'b0;
  logic [9:0] counter_H, counter_V;
  logic       hsync, vsync, display_on, vblank, frame_start;
  logic [5:0] rgb;
  logic [7:0] frame_count;

  int vectors = 0;
  int miscompares = 0;
  int t = 0;             // cycles since reset release
  bit prev_colour = 1'b0; // colour sampled at the edge that began this cycle

  vga_timing_generator #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COLOUR_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .colour(colour),
    .counter_H(counter_H), .counter_V(counter_V),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .rgb(rgb), .vblank(vblank), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_h(int tt); return tt % HT; endfunction
  function automatic int m_v(int tt); return (tt / HT) % VT; endfunction
  function automatic bit m_act(int tt);
    if (tt < 0) return 1'b0;
    return (m_h(tt) < HA) && (m_v(tt) < VA);
  endfunction
  function automatic bit m_hs(int tt);
    if (tt < 0) return 1'b1;
    return !(m_h(tt) >= HA + HF && m_h(tt) < HA + HF + HS);
  endfunction
  function automatic bit m_vs(int tt);
    if (tt < 0) return 1'b1;
    return !(m_v(tt) >= VA + VF && m_v(tt) < VA + VF + VS);
  endfunction

  // Advance one clock; inputs are changed and outputs sampled at negedge.
  task automatic tick();
    prev_colour = colour;
    @(negedge clk);
    t++;
  endtask

  task automatic test_reset();
    colour = 1'b1;
    reset  = 1'b0;
    repeat (5) begin
      tick();
      vectors++;
      if (counter_H !== 10'd0 || counter_V !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 ||
          rgb !== 6'd0 || display_on !== 1'b0 || frame_count !== 8'd0 ||
          frame_start !== 1'b0 || vblank !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_values: H=%0d V=%0d hs=%b vs=%b rgb=%h de=%b fc=%0d fs=%b vb=%b; need 0 0 1 1 00 0 0 0 0",
                 counter_H, counter_V, hsync, vsync, rgb, display_on, frame_count, frame_start, vblank);
      end
    end
    reset = 1'b1;
    t = 0;
  endtask

  task automatic test_h_wrap();
    for (int i = 0; i <= 2 * HT; i++) begin
      vectors++;
      if (int'(counter_H) !== m_h(t) || int'(counter_V) !== m_v(t) || vblank !== (m_v(t) >= VA)) begin
        miscompares++;
        $display("FAIL h_wrap t=%0d: H=%0d V=%0d vb=%b; need H=%0d V=%0d vb=%b",
                 t, counter_H, counter_V, vblank, m_h(t), m_v(t), m_v(t) >= VA);
      end
      colour = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic test_sync_windows();
    int hrun = 0, vrun = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      vectors++;
      if (hsync !== m_hs(t - LAT) || vsync !== m_vs(t - LAT) || display_on !== m_act(t - LAT) ||
          rgb !== ((m_act(t - LAT) && prev_colour) ? 6'h3F : 6'h00)) begin
        miscompares++;
        $display("FAIL sync_window t=%0d: hs=%b vs=%b de=%b rgb=%h; need hs=%b vs=%b de=%b rgb=%h",
                 t, hsync, vsync, display_on, rgb, m_hs(t - LAT), m_vs(t - LAT), m_act(t - LAT),
                 (m_act(t - LAT) && prev_colour) ? 6'h3F : 6'h00);
      end
      if (hsync === 1'b0) hrun++;
      else if (hrun != 0) begin
        vectors++;
        if (hrun != HS) begin
          miscompares++;
          $display("FAIL hsync_width: got %0d cycles, need %0d", hrun, HS);
        end
        hrun = 0;
      end
      if (vsync === 1'b0) vrun++;
      else if (vrun != 0) begin
        vectors++;
        if (vrun != VS * HT) begin
          miscompares++;
          $display("FAIL vsync_width: got %0d cycles, need %0d", vrun, VS * HT);
        end
        vrun = 0;
      end
      colour = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic test_colour_align();
    // Colour follows the PPU contract: white only for column 5 (last active column).
    for (int i = 0; i <= FT; i++) begin
      if (i > 0) begin
        vectors++;
        if (rgb !== ((m_act(t - LAT) && m_h(t - LAT) == 5) ? 6'h3F : 6'h00)) begin
          miscompares++;
          $display("FAIL colour_align t=%0d: rgb=%h; need %h", t, rgb,
                   (m_act(t - LAT) && m_h(t - LAT) == 5) ? 6'h3F : 6'h00);
        end
      end
      colour = (t - (LAT - 1) >= 0) && (m_h(t - (LAT - 1)) == 5);
      tick();
    end
    // Constant white: anything outside active video must still be black.
    colour = 1'b1;
    for (int i = 0; i <= FT; i++) begin
      if (i > 0) begin
        vectors++;
        if (rgb !== (m_act(t - LAT) ? 6'h3F : 6'h00)) begin
          miscompares++;
          $display("FAIL blanking t=%0d: rgb=%h; need %h", t, rgb, m_act(t - LAT) ? 6'h3F : 6'h00);
        end
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    for (int i = 0; i <= FT && !found; i++) begin
      if (m_h(t) == HA + HF + LAT && m_v(t) == 3) found = 1'b1;
      else begin
        colour = 1'($urandom_range(0, 1));
        tick();
      end
    end
    vectors++;
    if (!found || hsync !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_setup: found=%b hs=%b; need found=1 hs=0", found, hsync);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (counter_H !== 10'd0 || counter_V !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 ||
        rgb !== 6'd0 || display_on !== 1'b0 || frame_count !== 8'd0 ||
        frame_start !== 1'b0 || vblank !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: H=%0d V=%0d hs=%b vs=%b rgb=%h de=%b fc=%0d fs=%b vb=%b; need 0 0 1 1 00 0 0 0 0",
               counter_H, counter_V, hsync, vsync, rgb, display_on, frame_count, frame_start, vblank);
    end
    reset = 1'b1;
    t = 0;
    // Restart must look exactly like a fresh release, with a clean delay line.
    for (int i = 0; i < 2 * HT; i++) begin
      vectors++;
      if (int'(counter_H) !== m_h(t) || int'(counter_V) !== m_v(t) || hsync !== m_hs(t - LAT) ||
          display_on !== m_act(t - LAT)) begin
        miscompares++;
        $display("FAIL restart t=%0d: H=%0d V=%0d hs=%b de=%b; need H=%0d V=%0d hs=%b de=%b",
                 t, counter_H, counter_V, hsync, display_on, m_h(t), m_v(t), m_hs(t - LAT), m_act(t - LAT));
      end
      colour = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic test_frame_counter();
    int pulses = 0, last_pulse = 0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    t = 0;
    for (int i = 0; i <= 256 * FT; i++) begin
      vectors++;
      if (frame_start !== (t > 0 && t % FT == 0) || int'(frame_count) !== (t / FT) % 256) begin
        miscompares++;
        $display("FAIL frame t=%0d: fs=%b fc=%0d; need fs=%b fc=%0d",
                 t, frame_start, frame_count, t > 0 && t % FT == 0, (t / FT) % 256);
      end
      if (frame_start === 1'b1) begin
        vectors++;
        if (t - last_pulse != FT) begin
          miscompares++;
          $display("FAIL frame_spacing: got %0d cycles, need %0d", t - last_pulse, FT);
        end
        pulses++;
        last_pulse = t;
      end
      colour = 1'($urandom_range(0, 1));
      tick();
    end
    vectors++;
    if (pulses != 256 || frame_count !== 8'd0) begin
      miscompares++;
      $display("FAIL frame_wrap: pulses=%0d fc=%0d; need 256 and 0", pulses, frame_count);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_h_wrap();
    test_sync_windows();
    test_colour_align();
    test_mid_reset();
    test_frame_counter();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
